block_mem_mp: RTL and testbench
===============================

Name: block_mem_mp

Overview:
- Banked, multi-read-port block memory. Successor to the single-port block memory used by the SIMD datapath.
- Each cycle it accepts one contiguous block write of 0..BLOCK_SIZE elements and up to NUM_RD contiguous block reads.
- Addresses may be unaligned and wrap at DEPTH.
- Reads are registered, with valid flags and write-first forwarding, so the vector register file and load/store unit can share one storage array.

Parameters:
- DEPTH, 4096: total elements. Must be a power of two and a multiple of BLOCK_SIZE.
- SIZE, 32: element width in bits.
- BLOCK_SIZE, 4: elements per block access. Must be a power of two, ≥2.
- NUM_RD, 2: number of independent read ports, ≥1.
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register stage, giving latency 2.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wr_en  in  1  write request.
- i_addr_w  in  $clog2(DEPTH)  element address of write lane 0.
- i_data_w  in  [BLOCK_SIZE-1:0][SIZE-1:0]  write data; lane k targets i_addr_w+k.
- i_wr_size  in  $clog2(BLOCK_SIZE)+1  number of lanes to write, 0..BLOCK_SIZE.
- i_rd_en  in  NUM_RD  per-port read request.
- i_addr_r  in  [NUM_RD-1:0][$clog2(DEPTH)-1:0]  element address of read lane 0, per port.
- o_data  out  [NUM_RD-1:0][BLOCK_SIZE-1:0][SIZE-1:0]  read data; lane k = mem[i_addr_r+k].
- o_rd_valid  out  NUM_RD  per-port read data valid.
- o_wr_err  out  1  pulses when a write is rejected because i_wr_size > BLOCK_SIZE.

Behaviour:
- **Reset values:** o_rd_valid=0, o_data=0, o_wr_err=0, all pipeline valids cleared. Array contents are not reset.
- **Reset mid-operation:** in-flight reads are dropped (valids cleared). Asserting i_rst_n does not commit a write in that cycle.
- **Storage:** BLOCK_SIZE banks. Element address a lives in bank a%BLOCK_SIZE, row a/BLOCK_SIZE. Each bank has one write port and NUM_RD read ports.
- **Lane rotation:** unaligned block access needs a rotate of BLOCK_SIZE lanes by a%BLOCK_SIZE. Banks with index < a%BLOCK_SIZE use row+1.
- **Wrap-around:** address arithmetic is modulo DEPTH. Example: addr DEPTH-2 with BLOCK_SIZE 4 touches DEPTH-2, DEPTH-1, 0, 1.
- **Write:** on posedge with i_wr_en=1 and i_wr_size ≤ BLOCK_SIZE, lanes k < i_wr_size are written; other lanes are untouched. i_wr_size=0 is a legal no-op with no error.
- **Write rejection:** if i_wr_en=1 and i_wr_size > BLOCK_SIZE, nothing is written and o_wr_err=1 for exactly the next cycle.
- **Read, OUT_REG=0:** the request sampled at edge N presents o_data with o_rd_valid=1 after edge N, valid for one cycle.
  - If i_rd_en=0, o_rd_valid=0 on the next cycle and o_data holds its previous value.
- **Read, OUT_REG=1:** same as above with one extra cycle; the result appears after edge N+1.
- **Read-during-write, same edge:** overlapping elements return the NEW data (write-first). This is resolved per element: lanes outside the write window return old contents.
- **Multiple ports:** ports are fully independent; any number may read the same address in the same cycle.
- **Latency and throughput:** no back-pressure, no stalls. One read per port per cycle and one write per cycle, sustained.

Test Plan:
- Reset, then read port 0 at addr 0 with i_rd_en=1 → o_rd_valid[0]=1 one cycle later. While i_rst_n=0: o_data=0, o_rd_valid=0, o_wr_err=0.
- Write addr 5, size 4, data {lane0..3 = 0xA0,0xA1,0xA2,0xA3}; next cycle read port 1 at addr 5 → lanes 0xA0,0xA1,0xA2,0xA3. Read addr 6 → lanes 0–2 = 0xA1,0xA2,0xA3.
- Partial write: prefill addr 8..11 with 0x11. Write addr 8, size 2, data 0xBB → read addr 8 returns 0xBB,0xBB,0x11,0x11.
  - Separately, write with size 5 (BLOCK_SIZE=4) → o_wr_err=1 for one cycle and memory unchanged.
- Wrap: write addr DEPTH-2, size 4, data 1,2,3,4 → read addr DEPTH-2 returns 1,2,3,4; read addr 0 returns 3,4,x,x.
- Collision: same edge, write addr 16 size 4 (0xC0..0xC3) and both ports read addr 14 → both ports return old[14], old[15], 0xC0, 0xC1.
- OUT_REG=1 build: back-to-back reads at addr 0,4,8 on consecutive cycles → valid data returned 2 cycles after each request. Assert i_rst_n=0 in the cycle after the second request → no further o_rd_valid pulses.

Source files
------------

// File: rtl/block_mem_mp.sv
// Banked multi-read-port block memory with unaligned, wrapping block access.
// Each bank keeps one element per row. A block access at address a touches
// BLOCK_SIZE consecutive elements, so it hits every bank exactly once. Each bank
// works out which lane it serves, and the banks are rotated back into lane order
// on the read side.

module block_mem_mp_bank #(
    parameter int ROWS   = 1024,
    parameter int RW     = 10,
    parameter int SIZE   = 32,
    parameter int NUM_RD = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_we,
    input  logic [RW-1:0]                  i_wrow,
    input  logic [SIZE-1:0]                i_wdata,
    input  logic [NUM_RD-1:0]              i_re,
    input  logic [NUM_RD-1:0][RW-1:0]      i_rrow,
    output logic [NUM_RD-1:0][SIZE-1:0]    o_rdata
);
    logic [SIZE-1:0] mem [ROWS];

    // Storage write; no write lands while reset is held.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_we) mem[i_wrow] <= i_wdata;
    end

    // Registered read per port, write-first on a same-row collision, held when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (i_re[p]) o_rdata[p] <= (i_we && i_wrow == i_rrow[p]) ? i_wdata : mem[i_rrow[p]];
            end
        end
    end
endmodule

module block_mem_mp #(
    parameter int DEPTH      = 4096,
    parameter int SIZE       = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int NUM_RD     = 2,
    parameter int OUT_REG    = 0
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst_n,
    input  logic                                         i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]                     i_addr_w,
    input  logic [BLOCK_SIZE-1:0][SIZE-1:0]              i_data_w,
    input  logic [$clog2(BLOCK_SIZE):0]                  i_wr_size,
    input  logic [NUM_RD-1:0]                            i_rd_en,
    input  logic [NUM_RD-1:0][$clog2(DEPTH)-1:0]         i_addr_r,
    output logic [NUM_RD-1:0][BLOCK_SIZE-1:0][SIZE-1:0]  o_data,
    output logic [NUM_RD-1:0]                            o_rd_valid,
    output logic                                         o_wr_err
);
    localparam int AW     = $clog2(DEPTH);
    localparam int BW     = $clog2(BLOCK_SIZE);
    localparam int RW     = AW - BW;
    localparam int ROWS   = DEPTH / BLOCK_SIZE;
    localparam int STAGES = (OUT_REG != 0) ? 1 : 0;
    localparam logic [BW:0] BS_W = (BW+1)'(BLOCK_SIZE);

    logic                                         wr_ok;
    logic [BLOCK_SIZE-1:0]                        bank_we;
    logic [BLOCK_SIZE-1:0][RW-1:0]                bank_wrow;
    logic [BLOCK_SIZE-1:0][SIZE-1:0]              bank_wdata;
    logic [BLOCK_SIZE-1:0][NUM_RD-1:0][RW-1:0]    bank_rrow;
    logic [BLOCK_SIZE-1:0][NUM_RD-1:0][SIZE-1:0]  bank_rdata;
    logic [NUM_RD-1:0][BW-1:0]                    off_q;
    logic [STAGES:0][NUM_RD-1:0]                  vld_pipe;
    logic [NUM_RD-1:0][BLOCK_SIZE-1:0][SIZE-1:0]  rot;

    assign wr_ok = i_wr_en && (i_wr_size <= BS_W);

    // Bank b serves lane (b - a) mod BLOCK_SIZE. Its row comes from the full
    // element address a+lane, which gives both the row+1 step for low banks and
    // the wrap at DEPTH.
    for (genvar b = 0; b < BLOCK_SIZE; b++) begin : g_bank
        localparam logic [BW-1:0] BIDX = BW'(b);
        logic [BW-1:0] wk;
        logic [AW-1:0] welem;

        assign wk            = BIDX - i_addr_w[BW-1:0];
        assign welem         = i_addr_w + AW'(wk);
        assign bank_we[b]    = wr_ok && ({1'b0, wk} < i_wr_size);
        assign bank_wrow[b]  = welem[AW-1:BW];
        assign bank_wdata[b] = i_data_w[wk];

        for (genvar p = 0; p < NUM_RD; p++) begin : g_port
            logic [BW-1:0] rk;
            logic [AW-1:0] relem;
            assign rk              = BIDX - i_addr_r[p][BW-1:0];
            assign relem           = i_addr_r[p] + AW'(rk);
            assign bank_rrow[b][p] = relem[AW-1:BW];
        end

        block_mem_mp_bank #(
            .ROWS(ROWS), .RW(RW), .SIZE(SIZE), .NUM_RD(NUM_RD)
        ) u_bank (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_we    (bank_we[b]),
            .i_wrow  (bank_wrow[b]),
            .i_wdata (bank_wdata[b]),
            .i_re    (i_rd_en),
            .i_rrow  (bank_rrow[b]),
            .o_rdata (bank_rdata[b])
        );
    end

    // Valid shift register and the lane offset needed to un-rotate the bank outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
            off_q    <= '0;
        end else begin
            vld_pipe[0] <= i_rd_en;
            for (int s = 1; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
            for (int p = 0; p < NUM_RD; p++) begin
                if (i_rd_en[p]) off_q[p] <= i_addr_r[p][BW-1:0];
            end
        end
    end

    // Lane k of a port comes from bank (offset + k) mod BLOCK_SIZE.
    always_comb begin
        logic [BW-1:0] idx;
        idx = '0;
        rot = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                idx        = off_q[p] + BW'(k);
                rot[p][k]  = bank_rdata[idx][p];
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [NUM_RD-1:0][BLOCK_SIZE-1:0][SIZE-1:0] data_q;
        // Extra output stage; it captures only on valid so idle cycles hold the last result.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                data_q <= '0;
            end else begin
                for (int p = 0; p < NUM_RD; p++) begin
                    if (vld_pipe[0][p]) data_q[p] <= rot[p];
                end
            end
        end
        assign o_data = data_q;
    end else begin : g_noreg
        assign o_data = rot;
    end

    assign o_rd_valid = vld_pipe[STAGES];

    // Oversized write requests are dropped and flagged for one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_wr_err <= 1'b0;
        else          o_wr_err <= i_wr_en && (i_wr_size > BS_W);
    end
endmodule

// File: tb/tb_block_mem_mp.sv
// Bench for block_mem_mp: a latency-1 build driven from a vector table, plus a
// latency-2 build on the same inputs for the pipelined and mid-flight-reset cases.

module tb_block_mem_mp;
    logic                   clk = 1'b0;
    logic                   rst_n, rst2_n;
    logic                   wr_en;
    logic [11:0]            addr_w;
    logic [3:0][31:0]       data_w;
    logic [2:0]             wr_size;
    logic [1:0]             rd_en;
    logic [1:0][11:0]       addr_r;
    logic [1:0][3:0][31:0]  data1, data2;
    logic [1:0]             vld1, vld2;
    logic                   err1, err2;

    int checks = 0;
    int failures = 0;

    block_mem_mp #(.OUT_REG(0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_addr_w(addr_w),
        .i_data_w(data_w), .i_wr_size(wr_size), .i_rd_en(rd_en), .i_addr_r(addr_r),
        .o_data(data1), .o_rd_valid(vld1), .o_wr_err(err1)
    );

    block_mem_mp #(.OUT_REG(1)) dut2 (
        .i_clk(clk), .i_rst_n(rst2_n), .i_wr_en(wr_en), .i_addr_w(addr_w),
        .i_data_w(data_w), .i_wr_size(wr_size), .i_rd_en(rd_en), .i_addr_r(addr_r),
        .o_data(data2), .o_rd_valid(vld2), .o_wr_err(err2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        n;
        logic         we;
        logic [11:0]  aw;
        logic [127:0] dw;
        logic [2:0]   ws;
        logic [1:0]   re;
        logic [11:0]  a0, a1;
        logic [127:0] e0, e1;
        logic         err;
    } vec_t;

    typedef struct {
        logic [1:0]        v;
        logic [1:0][127:0] d;
        logic              e;
    } sb_t;

    vec_t         vt[13];
    sb_t          q1[$];
    logic [127:0] q2[$];
    logic [1:0][127:0] last1;
    logic [127:0] last2;

    function automatic logic [31:0] P(input int a);
        return 32'hF000_0000 + 32'(a);
    endfunction

    function automatic logic [127:0] L(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic vec_t mk(input string n, input logic we, input int aw, input logic [127:0] dw,
                                input int ws, input logic [1:0] re, input int a0, input int a1,
                                input logic [127:0] e0, input logic [127:0] e1, input logic err);
        vec_t v;
        v.n = n; v.we = we; v.aw = 12'(aw); v.dw = dw; v.ws = 3'(ws); v.re = re;
        v.a0 = 12'(a0); v.a1 = 12'(a1); v.e0 = e0; v.e1 = e1; v.err = err;
        return v;
    endfunction

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [11:0] aw, input logic [127:0] dw, input logic [2:0] ws,
                         input logic [1:0] re, input logic [11:0] a0, input logic [11:0] a1);
        wr_en = we; addr_w = aw; data_w = dw; wr_size = ws;
        rd_en = re; addr_r[0] = a0; addr_r[1] = a1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latency-2 build: check the valid pulse, pop the scoreboard on valid, else expect held data.
    task automatic chk2(input string n, input logic expv);
        chk($sformatf("%s_vld", n), 128'(vld2), 128'({1'b0, expv}));
        if (vld2[0]) begin
            if (q2.size() == 0) begin
                chk($sformatf("%s_unexpected", n), 128'(1), 128'(0));
            end else begin
                last2 = q2.pop_front();
                chk($sformatf("%s_data", n), data2[0], last2);
            end
        end else begin
            chk($sformatf("%s_hold", n), data2[0], last2);
        end
    endtask

    initial begin
        logic [31:0] A0, A1, A2, A3, C0, C1, C2, C3;
        A0 = 32'hA0; A1 = 32'hA1; A2 = 32'hA2; A3 = 32'hA3;
        C0 = 32'hC0; C1 = 32'hC1; C2 = 32'hC2; C3 = 32'hC3;

        vt[0]  = mk("wr5_rd0",  1, 5,    L(A0, A1, A2, A3), 4, 2'b01, 0, 0,
                    L(P(0), P(1), P(2), P(3)), '0, 0);
        vt[1]  = mk("rd6_rd5",  0, 0,    '0, 0, 2'b11, 6, 5,
                    L(A1, A2, A3, P(9)), L(A0, A1, A2, A3), 0);
        vt[2]  = mk("fill8",    1, 8,    L(32'h11, 32'h11, 32'h11, 32'h11), 4, 2'b00, 0, 0, '0, '0, 0);
        vt[3]  = mk("part8",    1, 8,    L(32'hBB, 32'hBB, 32'hBB, 32'hBB), 2, 2'b00, 0, 0, '0, '0, 0);
        vt[4]  = mk("rd8_rd7",  0, 0,    '0, 0, 2'b11, 8, 7,
                    L(32'hBB, 32'hBB, 32'h11, 32'h11), L(A2, 32'hBB, 32'hBB, 32'h11), 0);
        vt[5]  = mk("wr_sz5",   1, 20,   L(32'hEE, 32'hEE, 32'hEE, 32'hEE), 5, 2'b00, 0, 0, '0, '0, 1);
        vt[6]  = mk("rd20",     0, 0,    '0, 0, 2'b01, 20, 0,
                    L(P(20), P(21), P(22), P(23)), '0, 0);
        vt[7]  = mk("wrap_wr",  1, 4094, L(1, 2, 3, 4), 4, 2'b00, 0, 0, '0, '0, 0);
        vt[8]  = mk("wrap_rd",  0, 0,    '0, 0, 2'b11, 4094, 0,
                    L(1, 2, 3, 4), L(3, 4, P(2), P(3)), 0);
        vt[9]  = mk("collide",  1, 16,   L(C0, C1, C2, C3), 4, 2'b11, 14, 14,
                    L(P(14), P(15), C0, C1), L(P(14), P(15), C0, C1), 0);
        vt[10] = mk("sz0_rd",   1, 12,   L(32'hDD, 32'hDD, 32'hDD, 32'hDD), 0, 2'b11, 16, 12,
                    L(C0, C1, C2, C3), L(P(12), P(13), P(14), P(15)), 0);
        vt[11] = mk("part_fwd", 1, 30,   L(32'h77, 32'h77, 32'h77, 32'h77), 1, 2'b01, 28, 0,
                    L(P(28), P(29), 32'h77, P(31)), '0, 0);
        vt[12] = mk("idle",     0, 0,    '0, 0, 2'b00, 0, 0, '0, '0, 0);

        // Reset with reads requested: nothing may come out.
        rst_n = 1'b0; rst2_n = 1'b0;
        drive(0, 0, '0, 0, 2'b11, 0, 0);
        repeat (2) step();
        chk("rst_vld1", 128'(vld1), 0);
        chk("rst_data1", data1, 0);
        chk("rst_err1", 128'(err1), 0);
        chk("rst_vld2", 128'(vld2), 0);
        chk("rst_data2", data2, 0);
        chk("rst_err2", 128'(err2), 0);
        drive(0, 0, '0, 0, 2'b00, 0, 0);
        rst_n = 1'b1; rst2_n = 1'b1;

        // Known background: element a holds P(a).
        for (int a = 0; a < 1024; a++) begin
            drive(1, 12'(a * 4), L(P(a*4), P(a*4+1), P(a*4+2), P(a*4+3)), 4, 2'b00, 0, 0);
            step();
        end
        drive(0, 0, '0, 0, 2'b00, 0, 0);
        step();

        // Table-driven run on the latency-1 build.
        last1 = '0;
        for (int i = 0; i < 13; i++) begin
            sb_t s;
            drive(vt[i].we, vt[i].aw, vt[i].dw, vt[i].ws, vt[i].re, vt[i].a0, vt[i].a1);
            s.v = vt[i].re; s.d[0] = vt[i].e0; s.d[1] = vt[i].e1; s.e = vt[i].err;
            q1.push_back(s);
            step();
            if (q1.size() == 0) begin
                chk($sformatf("%s_sb_empty", vt[i].n), 128'(1), 128'(0));
            end else begin
                s = q1.pop_front();
                chk($sformatf("%s_vld", vt[i].n), 128'(vld1), 128'(s.v));
                for (int p = 0; p < 2; p++) begin
                    if (s.v[p]) last1[p] = s.d[p];
                    chk($sformatf("%s_p%0d", vt[i].n, p), data1[p], last1[p]);
                end
                chk($sformatf("%s_err", vt[i].n), 128'(err1), 128'(s.e));
            end
        end
        drive(0, 0, '0, 0, 2'b00, 0, 0);
        repeat (3) step();

        // Latency-2 build: back-to-back reads at 0, 4, 8.
        last2 = vt[11].e0;
        drive(0, 0, '0, 0, 2'b01, 0, 0);
        q2.push_back(L(3, 4, P(2), P(3)));
        step(); chk2("or_c1", 0);
        drive(0, 0, '0, 0, 2'b01, 4, 0);
        q2.push_back(L(P(4), A0, A1, A2));
        step(); chk2("or_c2", 1);
        drive(0, 0, '0, 0, 2'b01, 8, 0);
        q2.push_back(L(32'hBB, 32'hBB, 32'h11, 32'h11));
        step(); chk2("or_c3", 1);
        drive(0, 0, '0, 0, 2'b00, 0, 0);
        step(); chk2("or_c4", 1);
        step(); chk2("or_c5", 0);

        // Reset right after the second of two requests: the second must never appear.
        drive(0, 0, '0, 0, 2'b01, 0, 0);
        q2.push_back(L(3, 4, P(2), P(3)));
        step(); chk2("rr_c1", 0);
        drive(0, 0, '0, 0, 2'b01, 4, 0);
        q2.push_back(L(P(4), A0, A1, A2));
        step(); chk2("rr_c2", 1);
        rst2_n = 1'b0;
        drive(0, 0, '0, 0, 2'b00, 0, 0);
        q2.delete();
        last2 = '0;
        #1;
        chk("rr_rst_vld", 128'(vld2), 0);
        chk("rr_rst_data", data2, 0);
        step(); chk2("rr_c3", 0);
        rst2_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(); chk2($sformatf("rr_after%0d", c), 0);
        end
        chk("or_sb_left", 128'(q2.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
